// File: rtl/n64_serial_pkg.sv
// Shared types and constants for the N64 controller report serial path.
// Frame length depends on the REPORT_CHECKSUM_EN macro.
package n64_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SKIP  = 2'd2,
    WAIT  = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

`ifdef REPORT_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 32'd6;
`else
  localparam int unsigned FRAME_LEN = 32'd5;
`endif

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 32'd1);

`ifdef REPORT_CHECKSUM_EN
  function automatic logic [7:0] report_chk(input logic [31:0] d);
    return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction
`endif

endpackage

// File: rtl/cntlr_report_framer.sv
// Frames 32-bit controller reports as SYNC + 4 data bytes (+ XOR checksum when
// REPORT_CHECKSUM_EN is defined) for a UART TX byte interface.
module cntlr_report_framer
  import n64_serial_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cntlr_data,
  input  logic        cntlr_data_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        frame_active,
  output logic [7:0]  drop_cnt
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] frame_q, frame_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        frame_active_q, frame_active_d;
  logic [7:0]  drop_q, drop_d;

  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [2:0] i);
    case (i)
      3'd0:    return SYNC_BYTE;
      3'd1:    return d[31:24];
      3'd2:    return d[23:16];
      3'd3:    return d[15:8];
      3'd4:    return d[7:0];
`ifdef REPORT_CHECKSUM_EN
      3'd5:    return report_chk(d);
`endif
      default: return 8'h00;
    endcase
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= 3'd0;
      frame_q        <= 32'd0;
      hold_q         <= 32'd0;
      hold_vld_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      tx_start_q     <= 1'b0;
      frame_active_q <= 1'b0;
      drop_q         <= 8'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      frame_q        <= frame_d;
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      frame_active_q <= frame_active_d;
      drop_q         <= drop_d;
    end
  end

  // Next-state logic; outputs are precomputed for the cycle being entered.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    frame_d        = frame_q;
    hold_d         = hold_q;
    hold_vld_d     = hold_vld_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    frame_active_d = frame_active_q;
    drop_d         = drop_q;

    // Holding write happens before any promotion so a same-cycle report is kept.
    if (cntlr_data_rdy && (state_q != IDLE)) begin
      hold_d     = cntlr_data;
      hold_vld_d = 1'b1;
      if (hold_vld_q && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 8'd1;
      end else begin
        drop_d = drop_q;
      end
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      IDLE: begin
        if (cntlr_data_rdy) begin
          frame_d        = cntlr_data;
          idx_d          = 3'd0;
          state_d        = START;
          tx_start_d     = 1'b1;
          tx_data_d      = byte_sel(cntlr_data, 3'd0);
          frame_active_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = SKIP;
      SKIP:  state_d = WAIT;
      WAIT: begin
        if (tx_busy) begin
          state_d = WAIT;
        end else if (idx_q != LAST_IDX) begin
          idx_d      = idx_q + 3'd1;
          state_d    = START;
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel(frame_q, idx_q + 3'd1);
        end else if (hold_vld_d) begin
          frame_d        = hold_d;
          hold_vld_d     = 1'b0;
          idx_d          = 3'd0;
          state_d        = START;
          tx_start_d     = 1'b1;
          tx_data_d      = byte_sel(hold_d, 3'd0);
          frame_active_d = 1'b1;
        end else begin
          frame_active_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign frame_active = frame_active_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_cntlr_report_framer.sv
// Self-checking bench for cntlr_report_framer: a frame-schedule model predicts
// every output each cycle; directed tests pin the model with literal byte lists.
`timescale 1ns/1ps
module tb_cntlr_report_framer;

`ifdef REPORT_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cntlr_data;
  logic        cntlr_data_rdy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        frame_active;
  logic [7:0]  drop_cnt;

  cntlr_report_framer dut (
    .clk(clk), .rst_n(rst_n), .cntlr_data(cntlr_data), .cntlr_data_rdy(cntlr_data_rdy),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .frame_active(frame_active), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // UART model: busy for busy_len cycles starting the cycle after tx_start.
  int busy_len = 10;
  bit hold_busy = 1'b0;
  int bcnt = 0;
  bit prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt = 0; prev_start = 1'b0; tx_busy = 1'b0;
    end else begin
      if (prev_start) bcnt = busy_len;
      tx_busy = (bcnt > 0) || hold_busy;
      if (bcnt > 0) bcnt--;
      prev_start = tx_start;
    end
  end

  // Frame-schedule model: expectations for the next cycle.
  bit          m_active = 1'b0;
  int          m_pos = 0;
  int          m_sc = 0;
  int          cyc = 0;
  logic [7:0]  m_bytes [6];
  logic [31:0] m_pend = 32'd0;
  bit          m_pend_v = 1'b0;
  bit          e_start = 1'b0;
  bit          e_fa = 1'b0;
  logic [7:0]  e_data = 8'h00;
  logic [7:0]  e_drop = 8'h00;
  logic [7:0]  rx [$];
  int          n_starts = 0;

  function automatic void load(input logic [31:0] d);
    m_bytes[0] = 8'hA5;
    m_bytes[1] = d[31:24];
    m_bytes[2] = d[23:16];
    m_bytes[3] = d[15:8];
    m_bytes[4] = d[7:0];
    m_bytes[5] = d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    m_pos = 0;
  endfunction

  function automatic void start_byte();
    e_start  = 1'b1;
    e_data   = m_bytes[m_pos];
    e_fa     = 1'b1;
    m_sc     = cyc + 1;
    m_active = 1'b1;
  endfunction

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      m_active = 1'b0; m_pend_v = 1'b0;
      e_start = 1'b0; e_fa = 1'b0; e_data = 8'h00; e_drop = 8'h00;
    end else begin
      cyc++;
      chk("tx_start", 32'(tx_start), 32'(e_start));
      chk("tx_data", 32'(tx_data), 32'(e_data));
      chk("frame_active", 32'(frame_active), 32'(e_fa));
      chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
      if (tx_start) begin
        rx.push_back(tx_data);
        n_starts++;
      end
      e_start = 1'b0;
      if (!m_active) begin
        if (cntlr_data_rdy) begin
          load(cntlr_data);
          start_byte();
        end
      end else begin
        if (cntlr_data_rdy) begin
          if (m_pend_v && e_drop != 8'hFF) e_drop = e_drop + 8'd1;
          m_pend   = cntlr_data;
          m_pend_v = 1'b1;
        end
        if (cyc >= m_sc + 2 && !tx_busy) begin
          if (m_pos < NB - 1) begin
            m_pos++;
            start_byte();
          end else begin
            e_fa = 1'b0;
            if (m_pend_v) begin
              load(m_pend);
              m_pend_v = 1'b0;
              start_byte();
            end else begin
              m_active = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d);
    @(negedge clk);
    cntlr_data = d;
    cntlr_data_rdy = 1'b1;
    @(negedge clk);
    cntlr_data_rdy = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (frame_active && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("idle_timeout", 32'(frame_active), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (n_starts < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("start_timeout", 32'(n_starts >= target), 32'd1);
  endtask

  task automatic check_frame(input string name, input int base, input logic [47:0] e);
    chk({name, "_count"}, 32'(rx.size() >= base + NB), 32'd1);
    for (int i = 0; i < NB; i++) begin
      if (base + i < rx.size())
        chk(name, 32'(rx[base + i]), 32'(e[47 - 8*i -: 8]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int s0;
    rst_n = 1'b0;
    cntlr_data = 32'd0;
    cntlr_data_rdy = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_frame_active", 32'(frame_active), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single report, 10-cycle bytes.
    busy_len = 10;
    base = rx.size();
    send(32'h12345678);
    wait_idle(500);
    check_frame("frame_12345678", base, 48'hA5_12_34_56_78_08);
    chk("drop_after_single", 32'(drop_cnt), 32'd0);

    // Report arriving during byte 2 chains a back-to-back frame.
    busy_len = 3;
    base = rx.size();
    s0 = n_starts;
    send(32'h12345678);
    wait_starts(s0 + 3, 200);
    send(32'hAAAA5555);
    wait_idle(500);
    check_frame("chain_first", base, 48'hA5_12_34_56_78_08);
    check_frame("chain_second", base + NB, 48'hA5_AA_AA_55_55_00);

    // Overwrite: 2 is replaced by 3, one drop.
    busy_len = 1;
    base = rx.size();
    send(32'h1);
    send(32'h2);
    send(32'h3);
    wait_idle(500);
    check_frame("ovr_first", base, 48'hA5_00_00_00_01_01);
    check_frame("ovr_second", base + NB, 48'hA5_00_00_00_03_03);
    chk("drop_one", 32'(drop_cnt), 32'd1);

    // Saturation while the UART is held busy.
    busy_len = 10;
    hold_busy = 1'b1;
    send(32'hCAFEF00D);
    for (int i = 0; i < 300; i++) send(32'(i));
    chk("drop_saturate", 32'(drop_cnt), 32'hFF);
    hold_busy = 1'b0;
    wait_idle(2000);
    chk("drop_hold_sat", 32'(drop_cnt), 32'hFF);

    // Reset during byte 3 clears everything immediately.
    s0 = n_starts;
    send(32'h0BADF00D);
    wait_starts(s0 + 4, 300);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_frame_active", 32'(frame_active), 32'd0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = rx.size();
    send(32'hDEADBEEF);
    wait_idle(500);
    check_frame("post_rst", base, 48'hA5_DE_AD_BE_EF_22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
